// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush control, single-shot halt, and
// forwarding plus load-use hazard outputs derived from registered state.
module ex_mem_reg #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          exValid,
  input  logic [DW-1:0] exAluRes,
  input  logic [DW-1:0] exWriteData,
  input  logic [DW-1:0] exPcInc,
  input  logic          exMemRead,
  input  logic          exMemWrite,
  input  logic          exRegWrite,
  input  logic          exMemToReg,
  input  logic          exHalt,
  input  logic [RW-1:0] exWriteReg,
  output logic          memValid,
  output logic [DW-1:0] memAluRes,
  output logic [DW-1:0] memWriteData,
  output logic [DW-1:0] memPcInc,
  output logic          memMemRead,
  output logic          memMemWrite,
  output logic          memRegWrite,
  output logic          memMemToReg,
  output logic          memHalt,
  output logic [RW-1:0] memWriteReg,
  output logic          haltSeen,
  output logic          fwdEn,
  output logic [RW-1:0] fwdReg,
  output logic [DW-1:0] fwdData,
  output logic          loadUse
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] aluRes;
    logic [DW-1:0] writeData;
    logic [DW-1:0] pcInc;
    logic          memRead;
    logic          memWrite;
    logic          regWrite;
    logic          memToReg;
    logic          halt;
    logic [RW-1:0] writeReg;
  } stage_t;

  stage_t stage_d, stage_q;
  logic   halt_seen_d, halt_seen_q;

  // Next-state selection: halt freeze > flush > stall > invalid > load.
  always_comb begin
    stage_d     = stage_q;
    halt_seen_d = halt_seen_q;
    if (halt_seen_q || flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (!exValid) begin
      stage_d = '0;
    end else begin
      stage_d.valid     = 1'b1;
      stage_d.aluRes    = exAluRes;
      stage_d.writeData = exWriteData;
      stage_d.pcInc     = exPcInc;
      // Store wins over load; halt suppresses all side effects.
      stage_d.memRead   = exMemRead & ~exMemWrite & ~exHalt;
      stage_d.memWrite  = exMemWrite & ~exHalt;
      stage_d.regWrite  = exRegWrite & ~exHalt;
      stage_d.memToReg  = exMemToReg;
      stage_d.halt      = exHalt;
      stage_d.writeReg  = exWriteReg;
      if (exHalt) begin
        halt_seen_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Registered outputs and hazard signals, all from registered state only.
  always_comb begin
    memValid     = stage_q.valid;
    memAluRes    = stage_q.aluRes;
    memWriteData = stage_q.writeData;
    memPcInc     = stage_q.pcInc;
    memMemRead   = stage_q.memRead;
    memMemWrite  = stage_q.memWrite;
    memRegWrite  = stage_q.regWrite;
    memMemToReg  = stage_q.memToReg;
    memHalt      = stage_q.halt;
    memWriteReg  = stage_q.writeReg;
    haltSeen     = halt_seen_q;
    fwdEn        = stage_q.valid & stage_q.regWrite & ~stage_q.memToReg & ~stage_q.halt;
    fwdReg       = stage_q.writeReg;
    fwdData      = stage_q.aluRes;
    loadUse      = stage_q.valid & stage_q.memRead & stage_q.regWrite;
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a behavioural model of the stage.
module tb_ex_mem_reg;
  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst, stall, flush, exValid;
  logic [DW-1:0] exAluRes, exWriteData, exPcInc;
  logic          exMemRead, exMemWrite, exRegWrite, exMemToReg, exHalt;
  logic [RW-1:0] exWriteReg;
  logic          memValid;
  logic [DW-1:0] memAluRes, memWriteData, memPcInc;
  logic          memMemRead, memMemWrite, memRegWrite, memMemToReg, memHalt;
  logic [RW-1:0] memWriteReg;
  logic          haltSeen, fwdEn, loadUse;
  logic [RW-1:0] fwdReg;
  logic [DW-1:0] fwdData;

  ex_mem_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exValid(exValid),
    .exAluRes(exAluRes), .exWriteData(exWriteData), .exPcInc(exPcInc),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exRegWrite(exRegWrite),
    .exMemToReg(exMemToReg), .exHalt(exHalt), .exWriteReg(exWriteReg),
    .memValid(memValid), .memAluRes(memAluRes), .memWriteData(memWriteData),
    .memPcInc(memPcInc), .memMemRead(memMemRead), .memMemWrite(memMemWrite),
    .memRegWrite(memRegWrite), .memMemToReg(memMemToReg), .memHalt(memHalt),
    .memWriteReg(memWriteReg), .haltSeen(haltSeen), .fwdEn(fwdEn),
    .fwdReg(fwdReg), .fwdData(fwdData), .loadUse(loadUse)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Model of what the memory stage should hold.
  logic          mValid, mRd, mWr, mRw, mMtr, mHalt, mSeen;
  logic [DW-1:0] mAlu, mWd, mPc;
  logic [RW-1:0] mReg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    mValid = 0; mAlu = '0; mWd = '0; mPc = '0; mRd = 0; mWr = 0;
    mRw = 0; mMtr = 0; mHalt = 0; mReg = '0;
  endtask

  // Apply one rising edge to the model using the current inputs.
  task automatic model_edge();
    if (rst) begin
      model_bubble();
      mSeen = 0;
    end else if (mSeen || flush) begin
      model_bubble();
    end else if (stall) begin
      // hold
    end else if (!exValid) begin
      model_bubble();
    end else begin
      mValid = 1;
      mAlu   = exAluRes;
      mWd    = exWriteData;
      mPc    = exPcInc;
      mMtr   = exMemToReg;
      mReg   = exWriteReg;
      mHalt  = exHalt;
      if (exHalt) begin
        mRd = 0; mWr = 0; mRw = 0; mSeen = 1;
      end else begin
        mWr = exMemWrite;
        mRd = exMemRead && !exMemWrite;
        mRw = exRegWrite;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(memValid), 32'(mValid));
    check({tag, ".alu"}, 32'(memAluRes), 32'(mAlu));
    check({tag, ".wdata"}, 32'(memWriteData), 32'(mWd));
    check({tag, ".pcinc"}, 32'(memPcInc), 32'(mPc));
    check({tag, ".rd"}, 32'(memMemRead), 32'(mRd));
    check({tag, ".wr"}, 32'(memMemWrite), 32'(mWr));
    check({tag, ".rw"}, 32'(memRegWrite), 32'(mRw));
    check({tag, ".m2r"}, 32'(memMemToReg), 32'(mMtr));
    check({tag, ".halt"}, 32'(memHalt), 32'(mHalt));
    check({tag, ".wreg"}, 32'(memWriteReg), 32'(mReg));
    check({tag, ".seen"}, 32'(haltSeen), 32'(mSeen));
    check({tag, ".fwdEn"}, 32'(fwdEn), 32'(mValid && mRw && !mMtr && !mHalt));
    check({tag, ".fwdReg"}, 32'(fwdReg), 32'(mReg));
    check({tag, ".fwdData"}, 32'(fwdData), 32'(mAlu));
    check({tag, ".loadUse"}, 32'(loadUse), 32'(mValid && mRd && mRw));
  endtask

  // Check outputs are unaffected by the new inputs, clock once, check again.
  task automatic step(input string tag);
    check_all({tag, "/pre"});
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; exValid = 0;
    exAluRes = '0; exWriteData = '0; exPcInc = '0;
    exMemRead = 0; exMemWrite = 0; exRegWrite = 0; exMemToReg = 0; exHalt = 0;
    exWriteReg = '0;
  endtask

  task automatic rand_ex();
    exAluRes    = DW'($urandom());
    exWriteData = DW'($urandom());
    exPcInc     = DW'($urandom());
    exMemRead   = 1'($urandom());
    exMemWrite  = 1'($urandom());
    exRegWrite  = 1'($urandom());
    exMemToReg  = 1'($urandom());
    exWriteReg  = RW'($urandom());
  endtask

  initial begin
    model_bubble();
    mSeen = 0;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    step("reset");
    check("reset.valid0", 32'(memValid), 32'd0);
    check("reset.seen0", 32'(haltSeen), 32'd0);

    // Load in memory stage.
    idle();
    exValid = 1; exAluRes = 16'h0040; exMemRead = 1; exRegWrite = 1; exMemToReg = 1;
    exWriteReg = 3'd3;
    step("load");
    check("load.alu", 32'(memAluRes), 32'h0040);
    check("load.loadUse", 32'(loadUse), 32'd1);
    check("load.fwdEn", 32'(fwdEn), 32'd0);

    // ALU op then 3-cycle stall with changing inputs.
    idle();
    exValid = 1; exAluRes = 16'h1234; exRegWrite = 1; exWriteReg = 3'd5;
    step("aluop");
    for (int i = 0; i < 3; i++) begin
      exValid = 1; rand_ex(); stall = 1;
      step("stall");
      check("stall.alu", 32'(memAluRes), 32'h1234);
      check("stall.reg", 32'(memWriteReg), 32'd5);
      check("stall.fwdEn", 32'(fwdEn), 32'd1);
    end

    // Flush beats stall.
    idle();
    exValid = 1; rand_ex(); flush = 1; stall = 1;
    step("flushstall");
    check("flushstall.valid", 32'(memValid), 32'd0);
    check("flushstall.alu", 32'(memAluRes), 32'd0);

    // Store wins over load.
    idle();
    exValid = 1; exMemRead = 1; exMemWrite = 1; exWriteData = 16'hBEEF; exAluRes = 16'h0010;
    step("storewins");
    check("storewins.rd", 32'(memMemRead), 32'd0);
    check("storewins.wr", 32'(memMemWrite), 32'd1);
    check("storewins.wd", 32'(memWriteData), 32'hBEEF);

    // Invalid instruction becomes a bubble.
    idle();
    exMemWrite = 1; exRegWrite = 1;
    step("invalid");
    check("invalid.wr", 32'(memMemWrite), 32'd0);
    check("invalid.fwdEn", 32'(fwdEn), 32'd0);

    // Halt: one cycle of memHalt, then frozen until reset.
    idle();
    exValid = 1; exHalt = 1; exRegWrite = 1; exMemWrite = 1;
    step("halt");
    check("halt.memHalt", 32'(memHalt), 32'd1);
    check("halt.wr", 32'(memMemWrite), 32'd0);
    check("halt.rw", 32'(memRegWrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      exValid = 1; rand_ex(); stall = 1;
      step("frozen");
      check("frozen.memHalt", 32'(memHalt), 32'd0);
      check("frozen.valid", 32'(memValid), 32'd0);
      check("frozen.seen", 32'(haltSeen), 32'd1);
    end
    idle();
    rst = 1;
    step("haltrst");
    check("haltrst.seen", 32'(haltSeen), 32'd0);

    // Random traffic with occasional resets, stalls, flushes and halts.
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst     = ($urandom_range(0, 39) == 0);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      exValid = ($urandom_range(0, 3) != 0);
      exHalt  = ($urandom_range(0, 29) == 0);
      rand_ex();
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the data-memory stage.
- Captures the ALU result, store data, memory/write-back controls and halt from execute, and presents them registered to data memory and write-back.
- Implements stall (hold), flush (bubble), single-shot halt propagation so the memory dump fires exactly once, and EX-to-EX forwarding and load-use hazard outputs.

Parameters:
- DW, 16, data/address width
- RW, 3, register-index width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  load bubble next edge
- exValid  in  1  execute-stage instruction valid
- exAluRes  in  DW  ALU result / memory address
- exWriteData  in  DW  store data
- exPcInc  in  DW  PC+2 for link writes
- exMemRead  in  1  load
- exMemWrite  in  1  store
- exRegWrite  in  1  writes register file
- exMemToReg  in  1  write-back selects memory data
- exHalt  in  1  halt instruction
- exWriteReg  in  RW  destination register
- memValid  out  1  registered valid
- memAluRes, memWriteData, memPcInc  out  DW  registered data
- memMemRead, memMemWrite, memRegWrite, memMemToReg, memHalt  out  1  registered controls
- memWriteReg  out  RW  registered destination
- haltSeen  out  1  sticky: a valid halt has entered the memory stage
- fwdEn  out  1  forwarding source valid (combinational)
- fwdReg  out  RW  forwarded register index (combinational)
- fwdData  out  DW  forwarded value (combinational)
- loadUse  out  1  load occupies memory stage (combinational)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: every registered output, including haltSeen, is 0.
- Bubble = memValid 0, all control bits 0, all data fields 0, memWriteReg 0.
- Next-state priority, highest first:
  - rst: reset values.
  - haltSeen=1: load bubble. Ignores stall and flush; the pipeline stays frozen until rst.
  - flush: load bubble.
  - stall: hold all registers unchanged.
  - exValid=0: load bubble.
  - Otherwise: load all ex* fields.
- Load-time control rules:
  - Controls are captured only when exValid=1.
  - If exMemRead and exMemWrite are both 1, memMemRead is captured as 0 and memMemWrite as 1 (store wins).
  - If exHalt=1, capture memHalt=1 and force memMemRead, memMemWrite and memRegWrite to 0.
- haltSeen sets on the edge that loads a valid halt; it is cleared only by rst.
  - Consequence: memHalt is high for exactly one cycle. The following edge loads a bubble even if stall=1.
- A halt that arrives together with flush or stall is not captured and does not set haltSeen.
- Latency: one cycle from ex* inputs to mem* outputs. No combinational path from ex* to any output.
- Forwarding, combinational from registered state only:
  - fwdEn = memValid & memRegWrite & ~memMemToReg & ~memHalt
  - fwdReg = memWriteReg
  - fwdData = memAluRes
- loadUse = memValid & memMemRead & memRegWrite.
- Stall held across N cycles keeps outputs bit-identical for N cycles. fwdEn and loadUse remain asserted accordingly.
- Reset asserted mid-stall or mid-halt-freeze clears everything on that edge.

Test Plan:
- Reset, then exValid=1, exAluRes=16'h0040, exMemRead=1, exRegWrite=1, exMemToReg=1, exWriteReg=3 -> next cycle: memAluRes=16'h0040, memMemRead=1, loadUse=1, fwdEn=0.
- Load ALU op (exAluRes=16'h1234, exRegWrite=1, exMemToReg=0, exWriteReg=5), then stall=1 for 3 cycles with changing ex* inputs -> outputs stay 16'h1234/5, fwdEn=1 for all 3 cycles.
- Valid op with flush=1 and stall=1 together -> next cycle is a bubble (memValid=0, all outputs 0).
- exValid=1, exHalt=1, exRegWrite=1, exMemWrite=1 -> memHalt=1, memMemWrite=0, memRegWrite=0 for one cycle. Then haltSeen=1 and bubbles on every later edge despite valid inputs and stall=1. rst=1 clears haltSeen.
- exMemRead=1 and exMemWrite=1, exWriteData=16'hBEEF, exAluRes=16'h0010 -> memMemRead=0, memMemWrite=1, memWriteData=16'hBEEF.
- exValid=0 with exMemWrite=1, exRegWrite=1 -> bubble captured, no memory access, fwdEn=0.
